// File: rtl/fu_pkg.sv
// Shared constants and types for the function-unit sequencer.
package fu_pkg;

    localparam int unsigned FU_DATA_W = 16;
    localparam int unsigned FU_REG_N  = 8;
    localparam int unsigned FS_W      = 4;
    localparam int unsigned FLAG_W    = 4;
    localparam int unsigned CNT_W     = 3;

    // Function-select codes understood by the function unit
    localparam logic [FS_W-1:0] FS_MOVA  = 4'b0000;
    localparam logic [FS_W-1:0] FS_INC   = 4'b0001;
    localparam logic [FS_W-1:0] FS_ADD   = 4'b0010;
    localparam logic [FS_W-1:0] FS_ADDI  = 4'b0011;
    localparam logic [FS_W-1:0] FS_ADDNB = 4'b0100;
    localparam logic [FS_W-1:0] FS_SUB   = 4'b0101;
    localparam logic [FS_W-1:0] FS_DEC   = 4'b0110;
    localparam logic [FS_W-1:0] FS_MOVA2 = 4'b0111;
    localparam logic [FS_W-1:0] FS_AND   = 4'b1000;
    localparam logic [FS_W-1:0] FS_OR    = 4'b1001;
    localparam logic [FS_W-1:0] FS_XOR   = 4'b1010;
    localparam logic [FS_W-1:0] FS_NOT   = 4'b1011;
    localparam logic [FS_W-1:0] FS_MOVB  = 4'b1100;
    localparam logic [FS_W-1:0] FS_SHR   = 4'b1101;
    localparam logic [FS_W-1:0] FS_SHL   = 4'b1110;
    localparam logic [FS_W-1:0] FS_HOLD  = 4'b1111;

    // Bit positions inside the {V,C,N,Z} flag register
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/regfile8x16.sv
// Register file: two operand read ports, one debug read port, one write port.
module regfile8x16
    import fu_pkg::*;
#(
    parameter int unsigned DATA_W = FU_DATA_W,
    parameter int unsigned REG_N  = FU_REG_N,
    parameter int unsigned ADDR_W = $clog2(REG_N)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [ADDR_W-1:0] i_raddr_dbg,
    output logic [DATA_W-1:0] o_rdata_dbg
);

    logic [DATA_W-1:0] r_mem [REG_N];

    // Synchronous clear on reset, otherwise single-port write
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(REG_N); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a   = r_mem[i_raddr_a];
    assign o_rdata_b   = r_mem[i_raddr_b];
    assign o_rdata_dbg = r_mem[i_raddr_dbg];

endmodule

// File: rtl/fu_sequencer.sv
// Issue/writeback controller driving FS/A/B into a registered function unit.
module fu_sequencer
    import fu_pkg::*;
#(
    parameter int unsigned DATA_W     = FU_DATA_W,
    parameter int unsigned REG_N      = FU_REG_N,
    parameter int unsigned FU_LATENCY = 1
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [FS_W-1:0]           IN_OP,
    input  logic [$clog2(REG_N)-1:0]  IN_DA,
    input  logic [$clog2(REG_N)-1:0]  IN_SA,
    input  logic [$clog2(REG_N)-1:0]  IN_SB,
    input  logic                      IN_IMM_EN,
    input  logic [DATA_W-1:0]         IN_IMM,
    output logic [FS_W-1:0]           FS,
    output logic [DATA_W-1:0]         A,
    output logic [DATA_W-1:0]         B,
    input  logic [DATA_W-1:0]         D,
    input  logic                      V,
    input  logic                      C,
    input  logic                      N,
    input  logic                      Z,
    output logic                      DONE,
    output logic [DATA_W-1:0]         RESULT,
    output logic [FLAG_W-1:0]         FLAGS,
    input  logic [$clog2(REG_N)-1:0]  RD_ADDR,
    output logic [DATA_W-1:0]         RD_DATA
);

    localparam int unsigned ADDR_W = $clog2(REG_N);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_sample;
    logic [CNT_W-1:0]    r_cnt;
    logic [FS_W-1:0]     r_fs;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [ADDR_W-1:0]   r_da;
    logic                r_done;
    logic [DATA_W-1:0]   r_result;
    logic [FLAG_W-1:0]   r_flags;
    logic [FLAG_W-1:0]   w_flags_nxt;
    logic [DATA_W-1:0]   w_rdata_a;
    logic [DATA_W-1:0]   w_rdata_b;
    logic                w_we;
    logic                w_unused;

    // N and Z are recomputed locally from D
    assign w_unused = ^{N, Z};

    regfile8x16 #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .i_clk       (CLK),
        .i_reset     (RESET),
        .i_we        (w_we),
        .i_waddr     (r_da),
        .i_wdata     (D),
        .i_raddr_a   (IN_SA),
        .o_rdata_a   (w_rdata_a),
        .i_raddr_b   (IN_SB),
        .o_rdata_b   (w_rdata_b),
        .i_raddr_dbg (RD_ADDR),
        .o_rdata_dbg (RD_DATA)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus accept/sample strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (IN_VALID) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (r_cnt == CNT_W'(FU_LATENCY)) begin
                    w_sample    = 1'b1;
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Writeback is suppressed for the hold/NOP opcode latched at accept
    assign w_we = w_sample && (r_fs != FS_HOLD);

    // Flag update: N/Z from D, V/C only from arithmetic ops
    always_comb begin
        w_flags_nxt         = r_flags;
        w_flags_nxt[FLAG_N] = D[DATA_W-1];
        w_flags_nxt[FLAG_Z] = (D == '0);
        if (!r_fs[FS_W-1]) begin
            w_flags_nxt[FLAG_V] = V;
            w_flags_nxt[FLAG_C] = C;
        end
    end

    // Operand issue, latency counter, result/flag capture and DONE pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt    <= '0;
            r_fs     <= FS_MOVA;
            r_a      <= '0;
            r_b      <= '0;
            r_da     <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_done <= w_sample;
            if (w_accept) begin
                r_fs  <= IN_OP;
                r_a   <= w_rdata_a;
                r_b   <= IN_IMM_EN ? IN_IMM : w_rdata_b;
                r_da  <= IN_DA;
                r_cnt <= '0;
            end else if (r_state == EXEC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_sample) begin
                r_result <= D;
                r_flags  <= w_flags_nxt;
            end
        end
    end

    assign IN_READY = (r_state == IDLE);
    assign FS       = r_fs;
    assign A        = r_a;
    assign B        = r_b;
    assign DONE     = r_done;
    assign RESULT   = r_result;
    assign FLAGS    = r_flags;

endmodule

// File: tb/tb_fu_sequencer.sv
// Self-checking bench: behavioural function unit plus instruction-level reference model.
module tb_fu_sequencer;
    import fu_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [3:0]  IN_OP = 4'd0;
    logic [2:0]  IN_DA = 3'd0;
    logic [2:0]  IN_SA = 3'd0;
    logic [2:0]  IN_SB = 3'd0;
    logic        IN_IMM_EN = 1'b0;
    logic [15:0] IN_IMM = 16'd0;
    logic [3:0]  FS;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] D = 16'd0;
    logic        V = 1'b0;
    logic        C = 1'b0;
    logic        N = 1'b0;
    logic        Z = 1'b0;
    logic        DONE;
    logic [15:0] RESULT;
    logic [3:0]  FLAGS;
    logic [2:0]  RD_ADDR = 3'd0;
    logic [15:0] RD_DATA;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers, last result, flags
    logic [15:0] m_reg [8];
    logic [15:0] m_res;
    logic [3:0]  m_flags;

    fu_sequencer #(.DATA_W(16), .REG_N(8), .FU_LATENCY(1)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OP(IN_OP), .IN_DA(IN_DA), .IN_SA(IN_SA), .IN_SB(IN_SB),
        .IN_IMM_EN(IN_IMM_EN), .IN_IMM(IN_IMM), .FS(FS), .A(A), .B(B),
        .D(D), .V(V), .C(C), .N(N), .Z(Z), .DONE(DONE), .RESULT(RESULT),
        .FLAGS(FLAGS), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
    );

    always #5 CLK = ~CLK;

    // Function unit behaviour: returns {V, C, D}
    function automatic logic [17:0] fu_eval(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [15:0] prev);
        logic [15:0] y;
        logic        cin;
        logic [16:0] s;
        logic [15:0] d;
        logic        c;
        logic        v;
        y = 16'd0; cin = 1'b0; d = prev; c = 1'b0; v = 1'b0;
        case (op)
            4'd1: cin = 1'b1;
            4'd2: y = b;
            4'd3: begin y = b; cin = 1'b1; end
            4'd4: y = ~b;
            4'd5: begin y = ~b; cin = 1'b1; end
            4'd6: y = 16'hFFFF;
            default: ;
        endcase
        if (!op[3]) begin
            s = {1'b0, a} + {1'b0, y} + 17'(cin);
            d = s[15:0];
            c = s[16];
            v = (a[15] == y[15]) && (d[15] != a[15]);
        end else begin
            case (op)
                4'd8:    d = a & b;
                4'd9:    d = a | b;
                4'd10:   d = a ^ b;
                4'd11:   d = ~a;
                4'd12:   d = b;
                4'd13:   d = b >> 1;
                4'd14:   d = b << 1;
                default: d = prev;
            endcase
        end
        return {v, c, d};
    endfunction

    // Registered FU with latency 1; N/Z driven inverted so the DUT must ignore them
    always @(posedge CLK) begin
        logic [17:0] t;
        t = fu_eval(FS, A, B, D);
        V <= t[17];
        C <= t[16];
        D <= t[15:0];
        N <= ~t[15];
        Z <= (t[15:0] != 16'd0);
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'd0;
        m_res   = 16'd0;
        m_flags = 4'd0;
    endtask

    task automatic model_exec(input logic [3:0] op, input logic [2:0] da, input logic [2:0] sa,
                              input logic [2:0] sb, input logic ie, input logic [15:0] imm);
        logic [15:0] a;
        logic [15:0] b;
        logic [17:0] t;
        a = m_reg[sa];
        b = ie ? imm : m_reg[sb];
        t = fu_eval(op, a, b, m_res);
        m_res = t[15:0];
        m_flags[3] = op[3] ? m_flags[3] : t[17];
        m_flags[2] = op[3] ? m_flags[2] : t[16];
        m_flags[1] = t[15];
        m_flags[0] = (t[15:0] == 16'd0);
        if (op != 4'hF) m_reg[da] = t[15:0];
    endtask

    // Issue one instruction and observe the handshake; entered and left on a negedge
    task automatic run_instr(input logic [3:0] op, input logic [2:0] da, input logic [2:0] sa,
                             input logic [2:0] sb, input logic ie, input logic [15:0] imm,
                             input bit noise, output int lat, output logic [15:0] res,
                             output logic [3:0] flg, output bit rdy_low, output bit rdy_next,
                             output bit done_next);
        int g;
        g = 0;
        while (IN_READY !== 1'b1 && g < 20) begin
            @(negedge CLK);
            g++;
        end
        IN_OP = op; IN_DA = da; IN_SA = sa; IN_SB = sb; IN_IMM_EN = ie; IN_IMM = imm;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        lat = 99; res = 16'hDEAD; flg = 4'hX; rdy_low = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (IN_READY !== 1'b0) rdy_low = 1'b0;
            if (DONE === 1'b1) begin
                lat = k; res = RESULT; flg = FLAGS;
                IN_VALID = 1'b0;
                break;
            end
            if (noise && k < 3) begin
                IN_VALID = 1'($urandom); IN_OP = 4'($urandom); IN_DA = 3'($urandom);
                IN_SA = 3'($urandom); IN_SB = 3'($urandom); IN_IMM_EN = 1'($urandom);
                IN_IMM = 16'($urandom);
            end else begin
                IN_VALID = 1'b0;
            end
        end
        @(negedge CLK);
        rdy_next  = IN_READY;
        done_next = DONE;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", IN_READY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", DONE); end
        checks++; if (FLAGS !== 4'h0) begin errors++; $display("FAIL reset_flags got %h exp 0", FLAGS); end
        checks++; if (RESULT !== 16'h0) begin errors++; $display("FAIL reset_result got %h exp 0", RESULT); end
        checks++; if ({FS, A, B} !== 36'h0) begin errors++; $display("FAIL reset_fsab got %h %h %h exp 0", FS, A, B); end
        for (int i = 0; i < 8; i++) begin
            RD_ADDR = 3'(i);
            #1;
            checks++; if (RD_DATA !== 16'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", i, RD_DATA); end
        end
    endtask

    task automatic test_directed();
        int lat; logic [15:0] res; logic [3:0] flg; bit rl; bit rn; bit dn;
        // R0 <- imm 5
        run_instr(4'hC, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b0, lat, res, flg, rl, rn, dn);
        checks++; if (lat != 3) begin errors++; $display("FAIL dir_lat got %0d exp 3", lat); end
        checks++; if (rl !== 1'b1 || rn !== 1'b1) begin errors++; $display("FAIL dir_ready got low=%b next=%b exp 1 1", rl, rn); end
        checks++; if (dn !== 1'b0) begin errors++; $display("FAIL dir_done_width got %b exp 0", dn); end
        // R1 <- R0
        run_instr(4'h0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, lat, res, flg, rl, rn, dn);
        RD_ADDR = 3'd1; #1;
        checks++; if (RD_DATA !== 16'h0005) begin errors++; $display("FAIL dir_mova got %h exp 0005", RD_DATA); end
        checks++; if (flg !== 4'b0000) begin errors++; $display("FAIL dir_mova_flags got %b exp 0000", flg); end
        run_instr(4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0, lat, res, flg, rl, rn, dn);
        run_instr(4'hC, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001, 1'b0, lat, res, flg, rl, rn, dn);
        // R3 <- R1 + R2 wraps to zero with carry
        run_instr(4'h2, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0, lat, res, flg, rl, rn, dn);
        RD_ADDR = 3'd3; #1;
        checks++; if (RD_DATA !== 16'h0000 || res !== 16'h0000) begin errors++; $display("FAIL dir_add got %h/%h exp 0000", RD_DATA, res); end
        checks++; if (flg !== 4'b0101) begin errors++; $display("FAIL dir_add_flags got %b exp 0101", flg); end
        // R4 <- R1 & 0x8000, carry preserved
        run_instr(4'h8, 3'd4, 3'd1, 3'd0, 1'b1, 16'h8000, 1'b0, lat, res, flg, rl, rn, dn);
        RD_ADDR = 3'd4; #1;
        checks++; if (RD_DATA !== 16'h8000) begin errors++; $display("FAIL dir_and got %h exp 8000", RD_DATA); end
        checks++; if (flg !== 4'b0110) begin errors++; $display("FAIL dir_and_flags got %b exp 0110", flg); end
        // Hold/NOP targeting R5
        run_instr(4'hF, 3'd5, 3'd2, 3'd3, 1'b0, 16'h1234, 1'b0, lat, res, flg, rl, rn, dn);
        RD_ADDR = 3'd5; #1;
        checks++; if (RD_DATA !== 16'h0000) begin errors++; $display("FAIL dir_hold_nowrite got %h exp 0000", RD_DATA); end
        checks++; if (lat != 3) begin errors++; $display("FAIL dir_hold_done got lat %0d exp 3", lat); end
        checks++; if (res !== 16'h8000 || flg !== 4'b0110) begin errors++; $display("FAIL dir_hold_result got %h %b exp 8000 0110", res, flg); end
        // Sync the reference model with the directed sequence
        model_exec(4'hC, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0005);
        model_exec(4'h0, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0000);
        model_exec(4'hC, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF);
        model_exec(4'hC, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0001);
        model_exec(4'h2, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000);
        model_exec(4'h8, 3'd4, 3'd1, 3'd0, 1'b1, 16'h8000);
        model_exec(4'hF, 3'd5, 3'd2, 3'd3, 1'b0, 16'h1234);
    endtask

    task automatic test_reset_mid_exec();
        bit saw_done;
        IN_OP = 4'h2; IN_DA = 3'd6; IN_SA = 3'd0; IN_SB = 3'd4; IN_IMM_EN = 1'b0;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        checks++; if (IN_READY !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b exp 1", IN_READY); end
        checks++; if (RESULT !== 16'h0 || FLAGS !== 4'h0) begin errors++; $display("FAIL midrst_outs got %h %h exp 0 0", RESULT, FLAGS); end
        saw_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (DONE !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_done) begin errors++; $display("FAIL midrst_nodone got 1 exp 0"); end
        RD_ADDR = 3'd6; #1;
        checks++; if (RD_DATA !== 16'h0) begin errors++; $display("FAIL midrst_r6 got %h exp 0", RD_DATA); end
        RD_ADDR = 3'd4; #1;
        checks++; if (RD_DATA !== 16'h0) begin errors++; $display("FAIL midrst_r4 got %h exp 0", RD_DATA); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] res; logic [3:0] flg; bit rl; bit rn; bit dn;
        logic [15:0] imm;
        for (int i = 0; i < 6; i++) begin
            imm = 16'($urandom);
            run_instr(4'h2, 3'd7, 3'd7, 3'd0, 1'b1, imm, 1'b0, lat, res, flg, rl, rn, dn);
            model_exec(4'h2, 3'd7, 3'd7, 3'd0, 1'b1, imm);
            checks++; if (lat != 3 || rn !== 1'b1) begin errors++; $display("FAIL b2b_timing got lat %0d ready %b exp 3 1", lat, rn); end
            checks++; if (res !== m_res || flg !== m_flags) begin errors++; $display("FAIL b2b_result got %h %b exp %h %b", res, flg, m_res, m_flags); end
        end
        RD_ADDR = 3'd7; #1;
        checks++; if (RD_DATA !== m_reg[7]) begin errors++; $display("FAIL b2b_r7 got %h exp %h", RD_DATA, m_reg[7]); end
    endtask

    task automatic test_random();
        int lat; logic [15:0] res; logic [3:0] flg; bit rl; bit rn; bit dn;
        logic [3:0] op; logic [2:0] da; logic [2:0] sa; logic [2:0] sb; logic ie; logic [15:0] imm;
        for (int n = 0; n < 150; n++) begin
            op = 4'($urandom); da = 3'($urandom); sa = 3'($urandom); sb = 3'($urandom);
            ie = 1'($urandom); imm = 16'($urandom);
            if (n < 16) begin op = 4'hC; ie = 1'b1; da = 3'(n); end
            run_instr(op, da, sa, sb, ie, imm, 1'b1, lat, res, flg, rl, rn, dn);
            model_exec(op, da, sa, sb, ie, imm);
            checks++; if (lat != 3 || rl !== 1'b1 || rn !== 1'b1 || dn !== 1'b0) begin
                errors++; $display("FAIL rand_handshake n=%0d got lat %0d low %b next %b done %b exp 3 1 1 0", n, lat, rl, rn, dn);
            end
            checks++; if (res !== m_res) begin errors++; $display("FAIL rand_result n=%0d op=%h got %h exp %h", n, op, res, m_res); end
            checks++; if (flg !== m_flags) begin errors++; $display("FAIL rand_flags n=%0d op=%h got %b exp %b", n, op, flg, m_flags); end
            RD_ADDR = da; #1;
            checks++; if (RD_DATA !== m_reg[da]) begin errors++; $display("FAIL rand_reg n=%0d r%0d got %h exp %h", n, da, RD_DATA, m_reg[da]); end
        end
        for (int i = 0; i < 8; i++) begin
            RD_ADDR = 3'(i); #1;
            checks++; if (RD_DATA !== m_reg[i]) begin errors++; $display("FAIL rand_final_r%0d got %h exp %h", i, RD_DATA, m_reg[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
